oled_ram_arbiter: RTL

Write-port arbiter for the OLED frame RAM: up to `N_REQ` glyph writers share the single write port (`wr_en`/`wr_addr`/`wr_data`). Each writer requests ownership, receives a one-hot grant, and streams its writes, which are forwarded through one register stage. The arbiter uses round-robin priority, caps each grant by a beat limit, and revokes a stalled owner. It sits between the display writers and the frame RAM write port.

---
 rtl/oled_pkg.sv | 20 ++
 rtl/oled_ram_arbiter_if.sv | 35 +++
 rtl/oled_ram_arbiter_rr_pick.sv | 42 ++++
 rtl/oled_ram_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared definitions for the OLED frame RAM write path.
// Provides the default frame RAM geometry, the glyph size and the arbiter state type.
package oled_pkg;

    localparam int unsigned OLED_ADDR_W = 9;
    localparam int unsigned OLED_DATA_W = 8;
    localparam int unsigned GLYPH_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN     = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    // Width of an index into n items; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/oled_ram_arbiter_if.sv
// Bundle between the glyph writers and the frame RAM write port.
//   req, cl_wr_en, cl_wr_addr, cl_wr_data : per-writer requests and write streams (writer side)
//   gnt                                   : one-hot ownership grant back to the writers
//   wr_en, wr_addr, wr_data               : frame RAM write port
//   busy, err_drop, timeout_evt           : arbiter status
// The arbiter connects through modport slave, the writer/RAM side through modport master.
interface oled_ram_arbiter_if #(
    parameter int unsigned N_REQ  = 3,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 8
) ();

    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        cl_wr_en;
    logic [N_REQ*ADDR_W-1:0] cl_wr_addr;
    logic [N_REQ*DATA_W-1:0] cl_wr_data;
    logic [N_REQ-1:0]        gnt;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic                    busy;
    logic                    err_drop;
    logic                    timeout_evt;

    modport slave (
        input  req, cl_wr_en, cl_wr_addr, cl_wr_data,
        output gnt, wr_en, wr_addr, wr_data, busy, err_drop, timeout_evt
    );

    modport master (
        output req, cl_wr_en, cl_wr_addr, cl_wr_data,
        input  gnt, wr_en, wr_addr, wr_data, busy, err_drop, timeout_evt
    );

endinterface

// File: rtl/oled_ram_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req_i     : request vector
//   ptr_i     : index with highest priority this round
//   gnt_oh_o  : one-hot of the first set request scanning upward from ptr_i with wrap
//   gnt_idx_o : index of that request
//   valid_o   : at least one request is set
module rr_pick
    import oled_pkg::*;
#(
    parameter int unsigned N_REQ = 3,
    localparam int unsigned IdxW = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IdxW-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_oh_o,
    output logic [IdxW-1:0]  gnt_idx_o,
    output logic             valid_o
);

    always_comb begin
        int unsigned c;
        logic [IdxW-1:0] c_idx;
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        valid_o   = 1'b0;
        c         = 0;
        c_idx     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            c = 32'(ptr_i) + k;
            if (c >= N_REQ) begin
                c = c - N_REQ;
            end
            c_idx = IdxW'(c);
            if (!valid_o && req_i[c_idx]) begin
                valid_o          = 1'b1;
                gnt_oh_o[c_idx]  = 1'b1;
                gnt_idx_o        = c_idx;
            end
        end
    end

endmodule

// File: rtl/oled_ram_arbiter.sv
// Round-robin write-port arbiter for the OLED frame RAM.
//   clk_in   : system clock
//   rst_n_in : asynchronous active-low reset
//   bus      : writer requests/streams in, grant, registered RAM write port and status out
// A grant ends when the owner drops its request, completes MAX_BEATS writes, or stays
// silent for TIMEOUT cycles; a RELEASE cycle then advances the priority pointer.
module oled_ram_arbiter
    import oled_pkg::*;
#(
    parameter int unsigned N_REQ     = 3,
    parameter int unsigned ADDR_W    = OLED_ADDR_W,
    parameter int unsigned DATA_W    = OLED_DATA_W,
    parameter int unsigned MAX_BEATS = GLYPH_BYTES,
    parameter int unsigned TIMEOUT   = 64
) (
    input logic                clk_in,
    input logic                rst_n_in,
    oled_ram_arbiter_if.slave  bus
);

    localparam int unsigned IdxW   = idx_w(N_REQ);
    localparam int unsigned BeatsW = $clog2(MAX_BEATS + 1);
    localparam int unsigned IdleW  = $clog2(TIMEOUT + 1);

    arb_state_t        state_q, state_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [BeatsW-1:0] beats_q, beats_d;
    logic [IdleW-1:0]  idle_q, idle_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              err_q, err_d;
    logic              tmo_q, tmo_d;

    logic [N_REQ-1:0]  pick_oh;
    logic [IdxW-1:0]   pick_idx;
    logic              pick_valid;

    logic              own_wr;
    logic              own_req;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_data;
    logic [N_REQ-1:0]  drop_mask;
    logic              hit_beats;
    logic              hit_idle;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_i     (bus.req),
        .ptr_i     (ptr_q),
        .gnt_oh_o  (pick_oh),
        .gnt_idx_o (pick_idx),
        .valid_o   (pick_valid)
    );

    // Owner's slice of the writer buses.
    always_comb begin
        own_wr   = 1'b0;
        own_req  = 1'b0;
        own_addr = '0;
        own_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (owner_q == IdxW'(i)) begin
                own_wr   = bus.cl_wr_en[i];
                own_req  = bus.req[i];
                own_addr = bus.cl_wr_addr[i*ADDR_W +: ADDR_W];
                own_data = bus.cl_wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        beats_d   = beats_q;
        idle_d    = idle_q;
        gnt_d     = gnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        tmo_d     = 1'b0;
        drop_mask = bus.cl_wr_en;
        hit_beats = 1'b0;
        hit_idle  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    gnt_d   = pick_oh;
                    beats_d = '0;
                    idle_d  = '0;
                    state_d = OWN;
                end
            end
            OWN: begin
                // gnt_q is the owner's one-hot, so it masks the owner's strobe out.
                drop_mask = bus.cl_wr_en & ~gnt_q;
                if (own_wr) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = own_addr;
                    wr_data_d = own_data;
                    beats_d   = beats_q + 1'b1;
                    idle_d    = '0;
                    hit_beats = (beats_d == BeatsW'(MAX_BEATS));
                end else begin
                    idle_d    = idle_q + 1'b1;
                    hit_idle  = (idle_d == IdleW'(TIMEOUT));
                end
                if (!own_req || hit_beats || hit_idle) begin
                    gnt_d   = '0;
                    tmo_d   = hit_idle;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                gnt_d   = '0;
                ptr_d   = (owner_q == IdxW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        err_d = |drop_mask;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            beats_q   <= '0;
            idle_q    <= '0;
            gnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            beats_q   <= beats_d;
            idle_q    <= idle_d;
            gnt_q     <= gnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.err_drop    = err_q;
    assign bus.timeout_evt = tmo_q;

endmodule
